// File: rtl/gas_det_pkg.sv
// Shared types and defaults for the serial gas-signature monitor.
// Holds the FSM encoding, default signature set and small sizing helpers.
package gas_det_pkg;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        FILL    = 2'd1,
        MONITOR = 2'd2
    } state_t;

    localparam int DEF_NUM_GAS = 3;
    localparam int DEF_PAT_LEN = 8;
    localparam logic [DEF_NUM_GAS*DEF_PAT_LEN-1:0] DEF_PATTERNS = {8'hC3, 8'h9A, 8'h5B};

    // Bits needed to hold any value in 0..max_val (at least one).
    function automatic int width_for(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

    // A zero-length warm-up still occupies one cycle.
    function automatic int warm_last(input int cyc);
        return (cyc > 0) ? cyc - 1 : 0;
    endfunction

endpackage

// File: rtl/gas_pattern_monitor_if.sv
// Sensor-stream and alarm-status bundle between the sensor chain and the monitor.
// The master drives the stream and clears; the slave (monitor) reports status.
interface gas_pattern_monitor_if #(
    parameter int NUM_GAS = 3,
    parameter int CNT_W   = 8
);
    logic                     din;
    logic                     din_valid;
    logic                     restart;
    logic [NUM_GAS-1:0]       clr;
    logic                     ready;
    logic [NUM_GAS-1:0]       hit;
    logic [NUM_GAS-1:0]       alarm;
    logic [NUM_GAS*CNT_W-1:0] hit_cnt;
    logic                     irq;

    modport master (
        output din, din_valid, restart, clr,
        input  ready, hit, alarm, hit_cnt, irq
    );

    modport slave (
        input  din, din_valid, restart, clr,
        output ready, hit, alarm, hit_cnt, irq
    );
endinterface

// File: rtl/gas_alarm_channel.sv
// Per-gas sticky alarm and saturating hit counter; a hit always beats a clear.
// rise flags a 0->1 alarm transition one cycle ahead so the top can register irq.
module gas_alarm_channel
    import gas_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             hit,
    input  logic             clr,
    output logic             alarm,
    output logic [CNT_W-1:0] count,
    output logic             rise
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign rise = hit && !alarm;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            alarm <= 1'b0;
            count <= '0;
        end else if (hit) begin
            alarm <= 1'b1;
            if (clr)
                count <= CNT_W'(1);
            else if (count != CNT_MAX)
                count <= count + 1'b1;
        end else if (clr) begin
            alarm <= 1'b0;
            count <= '0;
        end
    end
endmodule

// File: rtl/gas_pattern_monitor.sv
// Serial detector for NUM_GAS programmable signatures with warm-up blanking,
// history fill tracking, per-gas alarm channels and an aggregate irq pulse.
module gas_pattern_monitor
    import gas_det_pkg::*;
#(
    parameter int                          NUM_GAS    = DEF_NUM_GAS,
    parameter int                          PAT_LEN    = DEF_PAT_LEN,
    parameter logic [NUM_GAS*PAT_LEN-1:0]  PATTERNS   = DEF_PATTERNS,
    parameter int                          CNT_W      = 8,
    parameter int                          WARMUP_CYC = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    gas_pattern_monitor_if.slave bus
);
    localparam int WARM_LAST = warm_last(WARMUP_CYC);
    localparam int WARM_W    = width_for(WARM_LAST);
    localparam int FILL_W    = width_for(PAT_LEN - 1);

    state_t                   state;
    state_t                   state_next;
    logic [WARM_W-1:0]        warm_cnt;
    logic [FILL_W-1:0]        fill_cnt;
    logic [PAT_LEN-1:0]       hist;
    logic [PAT_LEN-1:0]       hist_next;
    logic                     warm_done;
    logic                     fill_done;
    logic                     shift_en;
    logic                     cmp_en;
    logic [NUM_GAS-1:0]       match;
    logic [NUM_GAS-1:0]       rise;
    logic [NUM_GAS-1:0]       hit;
    logic                     irq;
    logic [NUM_GAS-1:0]       alarm_vec;
    logic [NUM_GAS*CNT_W-1:0] cnt_vec;

    assign warm_done = (warm_cnt == WARM_W'(WARM_LAST));
    assign fill_done = (fill_cnt == FILL_W'(PAT_LEN - 1));
    assign shift_en  = bus.din_valid && (state != WARMUP) && !bus.restart;
    // Comparing during FILL only on the completing bit guarantees PAT_LEN fresh bits.
    assign cmp_en    = shift_en && ((state == MONITOR) || ((state == FILL) && fill_done));
    assign hist_next = {hist[PAT_LEN-2:0], bus.din};

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            state <= WARMUP;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WARMUP:  if (warm_done) state_next = FILL;
            FILL:    if (!bus.restart && cmp_en) state_next = MONITOR;
            MONITOR: if (bus.restart) state_next = FILL;
            default: state_next = WARMUP;
        endcase
    end

    always_comb begin
        bus.ready = (state == MONITOR);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            warm_cnt <= '0;
            fill_cnt <= '0;
            hist     <= '0;
        end else begin
            if (state == WARMUP)
                warm_cnt <= warm_cnt + 1'b1;
            if (bus.restart && (state != WARMUP)) begin
                hist     <= '0;
                fill_cnt <= '0;
            end else if (shift_en) begin
                hist <= hist_next;
                if ((state == FILL) && !fill_done)
                    fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_GAS; g++) begin : g_gas
        assign match[g] = cmp_en && (hist_next == PATTERNS[g*PAT_LEN +: PAT_LEN]);

        gas_alarm_channel #(.CNT_W(CNT_W)) u_channel (
            .clk   (clk),
            .arst  (arst),
            .hit   (match[g]),
            .clr   (bus.clr[g]),
            .alarm (alarm_vec[g]),
            .count (cnt_vec[g*CNT_W +: CNT_W]),
            .rise  (rise[g])
        );
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hit <= '0;
            irq <= 1'b0;
        end else begin
            hit <= match;
            irq <= |rise;
        end
    end

    assign bus.hit     = hit;
    assign bus.irq     = irq;
    assign bus.alarm   = alarm_vec;
    assign bus.hit_cnt = cnt_vec;
endmodule

// File: tb/tb_gas_pattern_monitor.sv
// Directed plus randomized bench for gas_pattern_monitor; every cycle is compared
// against a bit-queue reference model of the detector's observable behaviour.
module tb_gas_pattern_monitor;
    import gas_det_pkg::*;

    localparam int NUM_GAS    = 3;
    localparam int PAT_LEN    = 8;
    localparam int CNT_W      = 2;
    localparam int WARMUP_CYC = 4;
    localparam logic [NUM_GAS*PAT_LEN-1:0] PATTERNS = {8'h9A, 8'hAA, 8'h5B};
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk  = 1'b0;
    logic arst = 1'b0;

    gas_pattern_monitor_if #(.NUM_GAS(NUM_GAS), .CNT_W(CNT_W)) bus ();

    gas_pattern_monitor #(
        .NUM_GAS    (NUM_GAS),
        .PAT_LEN    (PAT_LEN),
        .PATTERNS   (PATTERNS),
        .CNT_W      (CNT_W),
        .WARMUP_CYC (WARMUP_CYC)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the valid bits seen since the last flush, newest at the back.
    int               warm_left;
    bit               m_q[$];
    bit [NUM_GAS-1:0] m_hit;
    bit [NUM_GAS-1:0] m_alarm;
    bit               m_irq;
    int               m_cnt[NUM_GAS];

    task automatic modelReset();
        warm_left = (WARMUP_CYC > 0) ? WARMUP_CYC : 1;
        m_q.delete();
        m_hit   = '0;
        m_alarm = '0;
        m_irq   = 1'b0;
        for (int i = 0; i < NUM_GAS; i++) m_cnt[i] = 0;
    endtask

    task automatic modelStep(input bit d, input bit dv, input bit rs, input bit [NUM_GAS-1:0] cl);
        int win;
        m_hit = '0;
        m_irq = 1'b0;
        if (warm_left > 0) begin
            warm_left--;
        end else if (rs) begin
            m_q.delete();
        end else if (dv) begin
            m_q.push_back(d);
            if (m_q.size() > PAT_LEN) void'(m_q.pop_front());
            if (m_q.size() == PAT_LEN) begin
                win = 0;
                foreach (m_q[k]) win = win * 2 + int'(m_q[k]);
                for (int i = 0; i < NUM_GAS; i++)
                    if (win == int'(PATTERNS[i*PAT_LEN +: PAT_LEN])) m_hit[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_GAS; i++) begin
            if (m_hit[i]) begin
                if (!m_alarm[i]) m_irq = 1'b1;
                m_alarm[i] = 1'b1;
                m_cnt[i]   = cl[i] ? 1 : ((m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX);
            end else if (cl[i]) begin
                m_alarm[i] = 1'b0;
                m_cnt[i]   = 0;
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [NUM_GAS*CNT_W-1:0] exp_cnt;
        for (int i = 0; i < NUM_GAS; i++) exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        checkVal("ready",   32'(bus.ready),   32'(warm_left == 0 && m_q.size() == PAT_LEN));
        checkVal("hit",     32'(bus.hit),     32'(m_hit));
        checkVal("alarm",   32'(bus.alarm),   32'(m_alarm));
        checkVal("hit_cnt", 32'(bus.hit_cnt), 32'(exp_cnt));
        checkVal("irq",     32'(bus.irq),     32'(m_irq));
    endtask

    task automatic applyStimulus(input bit d, input bit dv, input bit rs, input bit [NUM_GAS-1:0] cl);
        bus.din       = d;
        bus.din_valid = dv;
        bus.restart   = rs;
        bus.clr       = cl;
        @(posedge clk);
        modelStep(d, dv, rs, cl);
        #1;
        checkOutput();
    endtask

    // Asynchronous reset must clear outputs before any clock edge arrives.
    task automatic doReset(input int hold);
        bus.din       = 1'b1;
        bus.din_valid = 1'b1;
        bus.restart   = 1'b0;
        bus.clr       = '0;
        arst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        repeat (hold) @(posedge clk);
        #1;
        checkOutput();
        arst = 1'b0;
    endtask

    task automatic sendBits(input logic [15:0] val, input int n, input int gap_pct,
                            input bit [NUM_GAS-1:0] clr_last);
        for (int b = n - 1; b >= 0; b--) begin
            for (int g = 0; g < 3; g++)
                if ($urandom_range(99) < gap_pct) applyStimulus(1'($urandom_range(1)), 1'b0, 1'b0, '0);
            applyStimulus(val[b], 1'b1, 1'b0, (b == 0) ? clr_last : '0);
        end
    endtask

    initial begin
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.restart   = 1'b0;
        bus.clr       = '0;
        #2;
        doReset(2);

        for (int i = 0; i < WARMUP_CYC + PAT_LEN; i++) applyStimulus(1'(i % 2), 1'b1, 1'b0, '0);

        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        sendBits(16'h005B, 8, 0, '0);
        checkVal("first_hit",   32'(bus.hit),   32'h1);
        checkVal("first_alarm", 32'(bus.alarm), 32'h1);
        checkVal("first_irq",   32'(bus.irq),   32'h1);

        sendBits(16'h0AAA, 12, 0, '0);

        for (int f = 0; f < 5; f++) sendBits(16'h009A, 8, 30, '0);

        sendBits(16'h009A, 8, 0, 3'b100);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b100);

        sendBits(16'h0018, 5, 0, '0);
        doReset(3);
        for (int i = 0; i < WARMUP_CYC + PAT_LEN + 2; i++)
            applyStimulus(1'($urandom_range(1)), 1'b1, 1'b0, '0);
        sendBits(16'h00AA, 8, 0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, '0);
        sendBits(16'h00AA, 8, 20, '0);

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(9))
                0, 1, 2: sendBits(16'(PATTERNS[$urandom_range(NUM_GAS-1)*PAT_LEN +: PAT_LEN]), 8, 20,
                                  ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b000);
                3:       if ($urandom_range(20) == 0) doReset(1 + $urandom_range(2));
                         else applyStimulus(1'($urandom_range(1)), 1'b1, 1'b1, '0);
                default: applyStimulus(1'($urandom_range(1)), 1'($urandom_range(4) != 0), 1'b0,
                                       ($urandom_range(15) == 0) ? 3'($urandom_range(7)) : 3'b000);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
